// File: rtl/ts_slot_mux_if.sv
// Byte-slot bus shared by the TS slot multiplexer, the PSI table inserter,
// the upstream packet FIFO and the T2-MI encapsulation stage.
interface ts_slot_mux_if;
  logic       out_en;
  logic       table_ready;
  logic [7:0] table_data;
  logic [7:0] payload_cnt;
  logic       table_sent;
  logic       pkt_avail;
  logic       fifo_rdreq;
  logic [7:0] fifo_q;
  logic [7:0] data_out;
  logic       dvalid;
  logic       psync;
  logic       sync_err;

  modport slave (
    input  out_en, table_ready, table_data, pkt_avail, fifo_q,
    output payload_cnt, table_sent, fifo_rdreq, data_out, dvalid, psync, sync_err
  );

  modport master (
    output out_en, table_ready, table_data, pkt_avail, fifo_q,
    input  payload_cnt, table_sent, fifo_rdreq, data_out, dvalid, psync, sync_err
  );
endinterface

// File: rtl/ts_slot_mux.sv
// TS slot multiplexer: at each packet boundary picks a table, stream or null
// source and emits one byte per slot strobe with a fixed two-cycle latency.
//
// state      | meaning
// SRC_NULL   | generated null packet in progress
// SRC_TABLE  | PSI/SI table packet in progress
// SRC_STREAM | service packet from the upstream FIFO in progress
module ts_slot_mux #(
  parameter int          PKT_LEN  = 188,
  parameter logic [12:0] NULL_PID = 13'h1FFF
) (
  input logic          clk_i,
  input logic          rst_n_i,
  ts_slot_mux_if.slave sm
);
  localparam logic [7:0] LAST_IDX  = 8'(PKT_LEN - 1);
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    SRC_NULL   = 2'd0,
    SRC_TABLE  = 2'd1,
    SRC_STREAM = 2'd2
  } src_e;

  src_e       src_q, src_d, cur_src;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] guard_q, guard_d;
  logic       last_table;

  logic       slot_vld_q;
  logic [7:0] slot_idx_q;
  src_e       slot_src_q;

  logic [7:0] null_byte, src_byte;
  logic [7:0] data_q, data_d;
  logic       dvalid_q, psync_q, sync_err_q, sync_err_d, sent_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_q <= SRC_NULL;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      cnt_q <= cnt_d;
    end
  end

  // At byte 0 the choice is live so the first byte of a packet already comes
  // from the newly selected source; afterwards the held choice applies.
  always_comb begin
    cur_src = src_q;
    if (cnt_q == '0) begin
      if (sm.table_ready && (guard_q == 2'd0)) cur_src = SRC_TABLE;
      else if (sm.pkt_avail)                   cur_src = SRC_STREAM;
      else                                     cur_src = SRC_NULL;
    end
    src_d = src_q;
    cnt_d = cnt_q;
    if (sm.out_en) begin
      src_d = cur_src;
      cnt_d = (cnt_q == LAST_IDX) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  assign last_table = sm.out_en && (cnt_q == LAST_IDX) && (cur_src == SRC_TABLE);

  // Guard spans the TABLE_SENT cycle and the one after, while the inserter's
  // registered ready is still being cleared.
  always_comb begin
    guard_d = guard_q;
    if (last_table)            guard_d = 2'd2;
    else if (guard_q != 2'd0)  guard_d = guard_q - 2'd1;
  end

  always_comb begin
    null_byte = 8'hFF;
    case (slot_idx_q)
      8'd0:    null_byte = SYNC_BYTE;
      8'd1:    null_byte = {3'b000, NULL_PID[12:8]};
      8'd2:    null_byte = NULL_PID[7:0];
      8'd3:    null_byte = 8'h10;
      default: null_byte = 8'hFF;
    endcase
  end

  always_comb begin
    src_byte = null_byte;
    case (slot_src_q)
      SRC_TABLE:  src_byte = sm.table_data;
      SRC_STREAM: src_byte = sm.fifo_q;
      default:    src_byte = null_byte;
    endcase
    data_d     = slot_vld_q ? src_byte : data_q;
    sync_err_d = slot_vld_q && (slot_src_q == SRC_STREAM) && (slot_idx_q == 8'd0) &&
                 (sm.fifo_q != SYNC_BYTE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      guard_q    <= '0;
      sent_q     <= 1'b0;
      slot_vld_q <= 1'b0;
      slot_idx_q <= '0;
      slot_src_q <= SRC_NULL;
      data_q     <= '0;
      dvalid_q   <= 1'b0;
      psync_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      guard_q    <= guard_d;
      sent_q     <= last_table;
      slot_vld_q <= sm.out_en;
      slot_idx_q <= cnt_q;
      slot_src_q <= cur_src;
      data_q     <= data_d;
      dvalid_q   <= slot_vld_q;
      psync_q    <= slot_vld_q && (slot_idx_q == 8'd0);
      sync_err_q <= sync_err_d;
    end
  end

  assign sm.payload_cnt = cnt_q;
  assign sm.fifo_rdreq  = sm.out_en && (cur_src == SRC_STREAM);
  assign sm.table_sent  = sent_q;
  assign sm.data_out    = data_q;
  assign sm.dvalid      = dvalid_q;
  assign sm.psync       = psync_q;
  assign sm.sync_err    = sync_err_q;
endmodule
